pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the load (`ld`) and clear (`clr`) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC load. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits (with timeout), and keeps saturating stall and flush statistics. It sits beside the pipeline registers and is the only block that drives their `ld`/`clr`.

## Interface
- `REG_W`, 5, register-address width
- `CNT_W`, 16, statistics counter width
- `INIT_CYCLES`, 4, cycles pipeline is held cleared after reset release (≥1)
- `MEM_TIMEOUT`, 8, max MEM_WAIT cycles before error (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `id_rs1`, `id_rs2` in REG_W: source registers of the instruction in ID
- `id_uses_rs2` in 1: ID instruction reads rs2
- `ex_rd` in REG_W: destination of the instruction in EX
- `ex_mem_read` in 1: EX instruction is a load
- `ex_branch_taken` in 1: branch/jump resolved taken in EX
- `mem_req` in 1: MEM instruction accesses data memory this cycle
- `mem_ready` in 1: data memory completes access this cycle
- `stat_clr` in 1: synchronous clear of statistics counters
- `pc_ld` out 1: PC load
- `ifid_ld`, `ifid_clr`, `idex_ld`, `idex_clr`, `exmem_ld`, `exmem_clr`, `memwb_ld`, `memwb_clr` out 1: pipeline register controls (clr has priority in the register)
- `busy` out 1: state ≠ RUN
- `mem_err` out 1: sticky memory-timeout flag, registered
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters, registered

## Operation
- States: INIT, RUN, MEM_WAIT, ERROR. Reset (rst=0) forces INIT, init counter 0, wait counter 0, `mem_err`=0, both stat counters 0.
- INIT: `pc_ld`=0, all `*_ld`=0, all `*_clr`=1. Goes to RUN after exactly INIT_CYCLES clock edges with rst=1.
- RUN, decisions in priority order (defaults: all `ld`=1, all `clr`=0, `pc_ld`=1):
  1. Memory stall (`mem_req` & !`mem_ready`): `pc_ld`, `ifid_ld`, `idex_ld`, `exmem_ld` = 0; `memwb_clr`=1; next state MEM_WAIT, wait counter ← 0. Branch and load-use are ignored this cycle.
  2. Branch flush (`ex_branch_taken`): defaults plus `ifid_clr`=1, `idex_clr`=1. Branch beats load-use.
  3. Load-use (`ex_mem_read` & `ex_rd`≠0 & (`ex_rd`==`id_rs1` | (`id_uses_rs2` & `ex_rd`==`id_rs2`))): `pc_ld`=0, `ifid_ld`=0, `idex_clr`=1; EX/MEM and MEM/WB advance.
  4. Otherwise: defaults.
- MEM_WAIT: while !`mem_ready`, outputs are the same as the RUN memory stall. If wait counter == MEM_TIMEOUT−1, go to ERROR; else increment it. When `mem_ready`=1: all defaults (pipeline advances, branch/load-use not evaluated), back to RUN. `mem_ready` wins over a timeout in the same cycle.
- ERROR: all `ld`=0, all `clr`=0, `pc_ld`=0 (pipeline frozen); `mem_err`=1 from the first ERROR cycle until reset. Only reset exits.
- `stall_cnt` +1 per cycle of memory stall (RUN or MEM_WAIT with !`mem_ready`) or load-use stall. `flush_cnt` +1 per branch-flush cycle. Both saturate at 2^CNT_W−1. `stat_clr` zeroes both and wins over a same-cycle increment. INIT and ERROR cycles never count.

## Timing
- All `ld`/`clr`/`pc_ld`/`busy` are combinational from the current state and current inputs, so they take effect at the same edge as the hazard.
- FSM, counters and `mem_err` update on the rising edge; reset is asynchronous.
- Memory stall latency: an access that is ready on its k-th cycle (k ≥ 2) stalls k−1 cycles. Maximum stall before ERROR is 1 + MEM_TIMEOUT cycles.
- Load-use costs exactly 1 bubble. A branch costs 2 squashed instructions.
- Reset asserted mid-MEM_WAIT or in ERROR: immediate INIT, counters 0, `mem_err` 0.

## Test plan
- Reset release, INIT_CYCLES=4 -> all clr=1 and ld=0 for 4 cycles, then RUN with all ld=1, `busy` 1→0, counters 0.
- Load x5, then dependent `id_rs1`=5 -> one cycle of `pc_ld`=0, `ifid_ld`=0, `idex_clr`=1; `stall_cnt`=1. Repeat with `ex_rd`=0 -> no stall.
- Same-cycle load-use and `ex_branch_taken` -> flush only (`ifid_clr`=`idex_clr`=1, `pc_ld`=1); `flush_cnt`=1, `stall_cnt` unchanged.
- `mem_req`=1, `mem_ready` rises on the 3rd cycle -> 2 stall cycles with `memwb_clr`=1, advance on the 3rd; `stall_cnt`=2; back in RUN.
- MEM_TIMEOUT=8, `mem_ready` held 0 -> 9 stall cycles, then ERROR: `mem_err`=1, all ld/clr=0. Separately, `mem_ready`=1 on the 8th MEM_WAIT cycle -> RUN, no error.
- CNT_W=4, 20 load-use stalls -> `stall_cnt` saturates at 15. `stat_clr` during a stall -> 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: drives ld/clr of the four pipeline registers and
// the PC load, resolving load-use, branch flush and data-memory waits with timeout.
module pipe_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             stat_clr,
    output logic             pc_ld,
    output logic             ifid_ld,
    output logic             ifid_clr,
    output logic             idex_ld,
    output logic             idex_clr,
    output logic             exmem_ld,
    output logic             exmem_clr,
    output logic             memwb_ld,
    output logic             memwb_clr,
    output logic             busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_MEM_WAIT,
        S_ERROR
    } state_t;

    state_t            state, state_d;
    logic [INIT_W-1:0] init_cnt, init_cnt_d;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
    logic              stall_ev, flush_ev;
    logic              mem_stall, load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & (ex_rd != '0) &
                       ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign busy      = (state != S_RUN);

    always_comb begin
        state_d    = state;
        init_cnt_d = init_cnt;
        wait_cnt_d = wait_cnt;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        pc_ld      = 1'b0;
        ifid_ld    = 1'b0;
        idex_ld    = 1'b0;
        exmem_ld   = 1'b0;
        memwb_ld   = 1'b0;
        ifid_clr   = 1'b0;
        idex_clr   = 1'b0;
        exmem_clr  = 1'b0;
        memwb_clr  = 1'b0;
        case (state)
            S_INIT: begin
                ifid_clr  = 1'b1;
                idex_clr  = 1'b1;
                exmem_clr = 1'b1;
                memwb_clr = 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_d    = S_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt + 1'b1;
                end
            end
            S_RUN: begin
                pc_ld    = 1'b1;
                ifid_ld  = 1'b1;
                idex_ld  = 1'b1;
                exmem_ld = 1'b1;
                memwb_ld = 1'b1;
                if (mem_stall) begin
                    // Freeze everything up to MEM; bubble into WB.
                    pc_ld      = 1'b0;
                    ifid_ld    = 1'b0;
                    idex_ld    = 1'b0;
                    exmem_ld   = 1'b0;
                    memwb_clr  = 1'b1;
                    stall_ev   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    ifid_clr = 1'b1;
                    idex_clr = 1'b1;
                    flush_ev = 1'b1;
                end else if (load_use) begin
                    pc_ld    = 1'b0;
                    ifid_ld  = 1'b0;
                    idex_clr = 1'b1;
                    stall_ev = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready) begin
                    // Completion takes precedence over a timeout in the same cycle.
                    pc_ld    = 1'b1;
                    ifid_ld  = 1'b1;
                    idex_ld  = 1'b1;
                    exmem_ld = 1'b1;
                    memwb_ld = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    memwb_ld  = 1'b1;
                    memwb_clr = 1'b1;
                    stall_ev  = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_d;
            init_cnt <= init_cnt_d;
            wait_cnt <= wait_cnt_d;
            mem_err  <= mem_err | (state_d == S_ERROR);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev) stall_cnt <= sat_inc(stall_cnt);
            if (flush_ev) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: RUN-state vector table plus hand sequences for
// reset/INIT, memory timeout, late-ready recovery and counter saturation.
module tb_pipe_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    // {busy, pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr, exmem_ld, exmem_clr, memwb_ld, memwb_clr}
    localparam logic [9:0] C_INIT  = 10'b1001010101;
    localparam logic [9:0] C_RUN   = 10'b0110101010;
    localparam logic [9:0] C_MSTL  = 10'b0000000011;
    localparam logic [9:0] C_MWAIT = 10'b1000000011;
    localparam logic [9:0] C_MRDY  = 10'b1110101010;
    localparam logic [9:0] C_BR    = 10'b0111111010;
    localparam logic [9:0] C_LU    = 10'b0000111010;
    localparam logic [9:0] C_ERR   = 10'b1000000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_uses_rs2 = 0, ex_mem_read = 0, ex_branch_taken = 0;
    logic mem_req = 0, mem_ready = 0, stat_clr = 0;
    logic pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr, exmem_ld, exmem_clr;
    logic memwb_ld, memwb_clr, busy, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [9:0] ctl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .INIT_CYCLES(4), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .stat_clr(stat_clr),
        .pc_ld(pc_ld), .ifid_ld(ifid_ld), .ifid_clr(ifid_clr),
        .idex_ld(idex_ld), .idex_clr(idex_clr), .exmem_ld(exmem_ld), .exmem_clr(exmem_clr),
        .memwb_ld(memwb_ld), .memwb_clr(memwb_clr), .busy(busy), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctl = {busy, pc_ld, ifid_ld, ifid_clr, idex_ld, idex_clr,
                  exmem_ld, exmem_clr, memwb_ld, memwb_clr};

    typedef struct {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use2;
        logic [REG_W-1:0] rd;
        logic             ld;
        logic             br;
        logic             req;
        logic             rdy;
        logic             sclr;
        logic [9:0]       ctl;
        int               stall;
        int               flush;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setin(input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
                         input logic u2, input logic [REG_W-1:0] rd, input logic ld,
                         input logic br, input logic req, input logic rdy, input logic sc);
        id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = u2; ex_rd = rd; ex_mem_read = ld;
        ex_branch_taken = br; mem_req = req; mem_ready = rdy; stat_clr = sc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        //                rs1 rs2 u2 rd  ld br rq rdy sc  ctl      stall flush
        vecs[0]  = '{ 0,  0,  0, 0,  0, 0, 0, 0,  0, C_RUN,   0, 0};
        vecs[1]  = '{ 5,  0,  0, 5,  1, 0, 0, 0,  0, C_LU,    1, 0};
        vecs[2]  = '{ 0,  0,  0, 0,  1, 0, 0, 0,  0, C_RUN,   1, 0};
        vecs[3]  = '{ 3,  7,  1, 7,  1, 0, 0, 0,  0, C_LU,    2, 0};
        vecs[4]  = '{ 3,  7,  0, 7,  1, 0, 0, 0,  0, C_RUN,   2, 0};
        vecs[5]  = '{ 5,  0,  0, 5,  0, 0, 0, 0,  0, C_RUN,   2, 0};
        vecs[6]  = '{ 5,  0,  0, 5,  1, 1, 0, 0,  0, C_BR,    2, 1};
        vecs[7]  = '{ 5,  0,  0, 5,  1, 1, 1, 0,  0, C_MSTL,  3, 1};
        vecs[8]  = '{ 0,  0,  0, 0,  0, 0, 1, 0,  0, C_MWAIT, 4, 1};
        vecs[9]  = '{ 5,  0,  0, 5,  1, 1, 1, 1,  0, C_MRDY,  4, 1};
        vecs[10] = '{ 0,  0,  0, 0,  0, 0, 0, 0,  0, C_RUN,   4, 1};
        vecs[11] = '{ 0,  0,  0, 0,  0, 0, 1, 1,  0, C_RUN,   4, 1};
        vecs[12] = '{ 9,  0,  0, 9,  1, 0, 0, 0,  1, C_LU,    0, 0};
        vecs[13] = '{ 0,  0,  0, 0,  0, 1, 0, 0,  0, C_BR,    0, 1};
        vecs[14] = '{ 0,  0,  0, 0,  0, 0, 0, 0,  1, C_RUN,   0, 0};

        // Reset release and INIT hold
        do_reset();
        chk("rst stall_cnt", 32'(stall_cnt), 0);
        chk("rst flush_cnt", 32'(flush_cnt), 0);
        chk("rst mem_err", 32'(mem_err), 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("init%0d ctl", i), 32'(ctl), 32'(C_INIT));
            tick();
        end
        chk("run after init ctl", 32'(ctl), 32'(C_RUN));
        chk("run after init stall_cnt", 32'(stall_cnt), 0);

        // RUN-state vector table
        for (int i = 0; i < 15; i++) begin
            setin(vecs[i].rs1, vecs[i].rs2, vecs[i].use2, vecs[i].rd, vecs[i].ld,
                  vecs[i].br, vecs[i].req, vecs[i].rdy, vecs[i].sclr);
            #1;
            chk($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vecs[i].ctl));
            tick();
            chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].stall));
            chk($sformatf("vec%0d flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].flush));
            chk($sformatf("vec%0d mem_err", i), 32'(mem_err), 0);
        end

        // Timeout: 9 stall cycles then ERROR
        setin(0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("to first ctl", 32'(ctl), 32'(C_MSTL));
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to wait%0d ctl", i), 32'(ctl), 32'(C_MWAIT));
            chk($sformatf("to wait%0d mem_err", i), 32'(mem_err), 0);
            tick();
        end
        chk("to err ctl", 32'(ctl), 32'(C_ERR));
        chk("to err mem_err", 32'(mem_err), 1);
        chk("to err stall_cnt", 32'(stall_cnt), 9);
        setin(5, 0, 0, 5, 1, 1, 1, 1, 0);
        tick();
        tick();
        chk("err frozen ctl", 32'(ctl), 32'(C_ERR));
        chk("err frozen mem_err", 32'(mem_err), 1);
        chk("err frozen stall_cnt", 32'(stall_cnt), 9);
        chk("err frozen flush_cnt", 32'(flush_cnt), 0);

        // Asynchronous reset out of ERROR
        #2;
        rst = 1'b0;
        #1;
        chk("async rst ctl", 32'(ctl), 32'(C_INIT));
        chk("async rst mem_err", 32'(mem_err), 0);
        chk("async rst stall_cnt", 32'(stall_cnt), 0);
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("rerun ctl", 32'(ctl), 32'(C_RUN));

        // mem_ready on the 8th MEM_WAIT cycle recovers without error
        setin(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        mem_ready = 1'b1;
        #1;
        chk("late rdy ctl", 32'(ctl), 32'(C_MRDY));
        tick();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("late rdy back ctl", 32'(ctl), 32'(C_RUN));
        chk("late rdy mem_err", 32'(mem_err), 0);
        chk("late rdy stall_cnt", 32'(stall_cnt), 8);

        // Saturation after 20 load-use stalls, then stat_clr during a stall
        setin(4, 0, 0, 4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat ctl", 32'(ctl), 32'(C_LU));
        chk("sat stall_cnt", 32'(stall_cnt), 15);
        stat_clr = 1'b1;
        tick();
        chk("sclr stall_cnt", 32'(stall_cnt), 0);
        stat_clr = 1'b0;
        tick();
        chk("post sclr stall_cnt", 32'(stall_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
